// File: rtl/divider16by8.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Overflow (high half >= divisor, including divisor = 0) completes immediately with an all-ones quotient.
module divider16by8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   trial;
    logic             qBit;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextShift;

    // One restoring step; the shift register holds the remaining dividend bits at
    // the top and collects quotient bits at the bottom.
    always_comb begin
        trial     = {prem_q, shift_q[WIDTH-1]};
        qBit      = (trial >= {1'b0, dvsr_q});
        // The difference is always below the divisor, so the low WIDTH bits are exact.
        nextRem   = qBit ? (trial[WIDTH-1:0] - dvsr_q) : trial[WIDTH-1:0];
        nextShift = {shift_q[WIDTH-2:0], qBit};
    end

    always_comb begin
        state_d = state_q;
        dvsr_d  = dvsr_q;
        prem_d  = prem_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvsr_d = divisor;
                    ovf_d  = 1'b0;
                    if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        prem_d  = dividend[2*WIDTH-1:WIDTH];
                        shift_d = dividend[WIDTH-1:0];
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d  = nextRem;
                shift_d = nextShift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quot_d  = nextShift;
                    rem_d   = nextRem;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvsr_q  <= '0;
            prem_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvsr_q  <= dvsr_d;
            prem_q  <= prem_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider16by8.sv
// Directed and random checks of divider16by8 against a plain-arithmetic division model.
module tb_divider16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    divider16by8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer division, with the overflow rule applied first.
    task automatic refDiv(input logic [15:0] dd, input logic [7:0] dv,
                          output logic [7:0] q, output logic [7:0] r, output logic o);
        int unsigned qi;
        int unsigned ri;
        if (dv == 8'd0 || dd[15:8] >= dv) begin
            q = 8'hFF;
            r = 8'h00;
            o = 1'b1;
        end else begin
            qi = 32'(dd) / 32'(dv);
            ri = 32'(dd) % 32'(dv);
            q  = qi[7:0];
            r  = ri[7:0];
            o  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] dd, input logic [7:0] dv);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic waitDone(output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] dd, input logic [7:0] dv);
        logic [7:0] eq, er;
        logic       eo;
        int         lat, bc;
        refDiv(dd, dv, eq, er, eo);
        waitDone(lat, bc);
        chk({tag, "_latency"}, lat, eo ? 1 : 9);
        chk({tag, "_busycycles"}, bc, eo ? 0 : 8);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_ovf"}, ovf, eo);
        @(negedge clk);
        chk({tag, "_donepulse"}, done, 1'b0);
    endtask

    initial begin
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  hi;
        int          lat, bc, doneCnt;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_quotient", quotient, 8'd0);
        chk("reset_remainder", remainder, 8'd0);
        chk("reset_ovf", ovf, 1'b0);
        rst = 1'b0;

        applyStimulus(16'hFE01, 8'hFF);
        checkOutput("max", 16'hFE01, 8'hFF);

        applyStimulus(16'd1000, 8'd7);
        checkOutput("d1000by7", 16'd1000, 8'd7);
        repeat (19) @(negedge clk);
        chk("hold_quotient", quotient, 8'd142);
        chk("hold_remainder", remainder, 8'd6);
        chk("hold_ovf", ovf, 1'b0);

        applyStimulus(16'h1234, 8'h12);
        checkOutput("ovf_high", 16'h1234, 8'h12);
        applyStimulus(16'h1234, 8'h00);
        checkOutput("ovf_zero", 16'h1234, 8'h00);

        // start held high through CALC and DONE with operands changing after accept
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 8'd3;
        @(posedge clk);
        #1;
        dividend = 16'd50; divisor = 8'd5;
        waitDone(lat, bc);
        chk("held_latency", lat, 9);
        chk("held_quotient", quotient, 8'd33);
        chk("held_remainder", remainder, 8'd1);
        chk("held_ovf", ovf, 1'b0);
        @(negedge clk);
        chk("held_idle_done", done, 1'b0);
        chk("held_idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat, bc);
        chk("second_latency", lat, 9);
        chk("second_quotient", quotient, 8'd10);
        chk("second_remainder", remainder, 8'd0);

        // reset in the middle of a division
        applyStimulus(16'hFE01, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_quotient", quotient, 8'd0);
        chk("abort_remainder", remainder, 8'd0);
        chk("abort_ovf", ovf, 1'b0);
        doneCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        chk("abort_nodone", doneCnt, 0);
        applyStimulus(16'd81, 8'd9);
        checkOutput("after_abort", 16'd81, 8'd9);

        // random in-range divisions: exact model plus the division identity
        for (int n = 0; n < 1000; n++) begin
            dv = 8'($urandom_range(1, 255));
            hi = 8'($urandom_range(0, int'(dv) - 1));
            dd = {hi, 8'($urandom)};
            applyStimulus(dd, dv);
            checkOutput("rand", dd, dv);
            chk("rand_identity", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
            chk("rand_rem_lt_div", (remainder < dv) ? 1 : 0, 1);
        end

        // unconstrained operands, overflow cases included
        for (int n = 0; n < 200; n++) begin
            dd = 16'($urandom);
            dv = 8'($urandom);
            applyStimulus(dd, dv);
            checkOutput("any", dd, dv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
